mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning the number of consecutive mem_req cycles without mem_ack before the access is aborted; legal range 2..65535.
REQ-002 SHALL have parameter BIG_ENDIAN, default 1, meaning byte offset 0 maps to bits 31:24 when 1 and to bits 7:0 when 0.
REQ-003 clk  in  1  single clock; all flops on posedge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low; this is the block's one clock and one reset.
REQ-005 valid_in  in  1  the execute-stage result on addr is valid this cycle.
REQ-006 opcode  in  6  MIPS primary opcode of the instruction, delayed to align with addr.
REQ-007 addr  in  32  execute-stage result: effective address for loads/stores, otherwise the result value.
REQ-008 wdata  in  32  rt value for stores.
REQ-009 rd_in  in  5  destination register.
REQ-010 stall  out  1  combinational; 1 means upstream SHALL hold all inputs stable.
REQ-011 mem_req / mem_we  out  1 / 1  memory request and write enable.
REQ-012 mem_addr / mem_wdata / mem_be  out  32 / 32 / 4  word address (bits 1:0 = 0), write data, byte enables.
REQ-013 mem_ack / mem_rdata  in  1 / 32  access complete; read word valid while mem_ack=1.
REQ-014 wb_valid / wb_rd / wb_data  out  1 / 5 / 32  registered writeback.
REQ-015 exc_adel / exc_ades / bus_err  out  1 / 1 / 1  one-cycle pulses: misaligned load, misaligned store, timeout.

Function
REQ-016 Memory opcodes SHALL be: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B; every other opcode is a pass-through.
REQ-017 FSM SHALL have exactly two states: IDLE and WAIT; stall = (state==WAIT).
REQ-018 IDLE, valid_in, pass-through: next cycle wb_valid=1, wb_rd=rd_in, wb_data=addr; state stays IDLE.
REQ-019 IDLE, valid_in, aligned memory op (half: addr[0]=0; word: addr[1:0]=0): at that edge, register mem_addr={addr[31:2],2'b00}, mem_we, mem_be and mem_wdata, set mem_req=1, and go to WAIT.
REQ-020 Misaligned access SHALL issue no request: next cycle the matching exc_adel/exc_ades=1 and wb_valid=0.
REQ-021 mem_req, mem_addr, mem_we, mem_be and mem_wdata SHALL stay constant throughout WAIT; mem_ack SHALL be ignored while mem_req=0.
REQ-022 WAIT with mem_ack=1: go to IDLE and drop mem_req at that edge. A load drives wb_valid=1 with extracted data next cycle; a store drives wb_valid=0.
REQ-023 Byte lane o=addr[1:0] (BIG_ENDIAN=1): LB/LBU use mem_rdata[31-8o -: 8]; LH/LHU use bits 31:16 for o=0 and 15:0 for o=2. LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend. BIG_ENDIAN=0 mirrors the lanes.
REQ-024 Store encoding (BIG_ENDIAN=1): SB mem_be=4'b1000>>o with mem_wdata={4{wdata[7:0]}}; SH mem_be=1100 (o=0) or 0011 (o=2) with mem_wdata={2{wdata[15:0]}}; SW mem_be=1111 with mem_wdata=wdata. Loads SHALL drive mem_be=1111.
REQ-025 Minimum load latency SHALL be: accept at edge N, mem_req high in cycle N+1, ack in cycle N+1, wb_valid high in cycle N+2.
REQ-026 A wait counter SHALL reset to 0 on entering WAIT and increment each WAIT cycle without ack. If the TIMEOUT-th req cycle has no ack: drop mem_req, go to IDLE, bus_err=1 next cycle, wb_valid=0.
REQ-027 Ack in the TIMEOUT-th cycle SHALL complete normally, with no bus_err.
REQ-028 wb_valid, exc_* and bus_err SHALL be 0 in every cycle not named above. valid_in is ignored while stall=1.

Reset
REQ-029 While rst_n=0: state=IDLE, counter=0, and mem_req, mem_we, wb_valid, exc_adel, exc_ades, bus_err=0; mem_addr, mem_wdata, wb_data=0; mem_be=0; wb_rd=0.
REQ-030 Assertion of rst_n mid-WAIT SHALL clear mem_req asynchronously and never produce wb_valid for the aborted access.
REQ-031 First acceptance SHALL be possible at the first posedge after rst_n rises.

Verification
REQ-032 Pass-through: opcode 0x00, addr=0x1234_5678, rd_in=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234_5678, stall=0.
REQ-033 LB: addr=0x100, ack after 3 cycles with rdata=0x80FF_0000 -> mem_addr=0x100, mem_be=1111, stall high 3 cycles, wb_data=0xFFFF_FF80. Repeat as LBU -> wb_data=0x0000_0080.
REQ-034 SH: addr=0x202, wdata=0xAAAA_BEEF, immediate ack -> mem_addr=0x200, mem_be=0011, mem_wdata=0xBEEF_BEEF, mem_we=1, wb_valid=0.
REQ-035 Misaligned: LW at addr=0x101 -> exc_adel=1 for one cycle, mem_req never rises. SH at 0x203 -> exc_ades=1 for one cycle.
REQ-036 Timeout: TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, bus_err=1 in the 5th, and the next instruction is accepted. Ack in the 4th cycle instead -> normal completion, no bus_err.
REQ-037 Reset mid-WAIT: rst_n low for 1 cycle during LW -> mem_req falls immediately, no wb_valid, and all outputs equal their REQ-029 values.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS memory stage: issues one load/store at a time to a request/ack memory port,
// extracts and extends load data, and raises address and bus-timeout exceptions.
module mem_stage #(
    parameter int unsigned TIMEOUT    = 256,
    parameter int unsigned BIG_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err
);

    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSb  = 6'h28;
    localparam logic [5:0] OpSh  = 6'h29;
    localparam logic [5:0] OpSw  = 6'h2B;

    localparam logic [1:0]  SzByte = 2'd0;
    localparam logic [1:0]  SzHalf = 2'd1;
    localparam logic [1:0]  SzWord = 2'd2;
    localparam logic        BeMode = (BIG_ENDIAN != 0);
    localparam logic [15:0] CntMax = 16'(TIMEOUT - 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        ld_q, ld_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_adel_q, exc_adel_d;
    logic        exc_ades_q, exc_ades_d;
    logic        bus_err_q, bus_err_d;

    logic        is_load, is_store, is_sign, misaligned;
    logic [1:0]  size_in;
    logic [1:0]  lane_in, lane_q;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Decode the incoming opcode into access kind, size and extension.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_sign  = 1'b0;
        size_in  = SzWord;
        case (opcode)
            OpLb:    begin is_load = 1'b1; size_in = SzByte; is_sign = 1'b1; end
            OpLh:    begin is_load = 1'b1; size_in = SzHalf; is_sign = 1'b1; end
            OpLw:    begin is_load = 1'b1; size_in = SzWord; end
            OpLbu:   begin is_load = 1'b1; size_in = SzByte; end
            OpLhu:   begin is_load = 1'b1; size_in = SzHalf; end
            OpSb:    begin is_store = 1'b1; size_in = SzByte; end
            OpSh:    begin is_store = 1'b1; size_in = SzHalf; end
            OpSw:    begin is_store = 1'b1; size_in = SzWord; end
            default: ;
        endcase
        misaligned = ((size_in == SzHalf) && addr[0]) ||
                     ((size_in == SzWord) && (addr[1:0] != 2'b00));
    end

    // Store lane enables and replicated write data; loads always enable the whole word.
    always_comb begin
        // Big-endian puts byte offset 0 in the top lane, i.e. lane = 3 - offset.
        lane_in = BeMode ? ~addr[1:0] : addr[1:0];
        st_be   = 4'b1111;
        st_data = wdata;
        if (is_store) begin
            case (size_in)
                SzByte: begin
                    st_be   = 4'b0001 << lane_in;
                    st_data = {4{wdata[7:0]}};
                end
                SzHalf: begin
                    st_be   = lane_in[1] ? 4'b1100 : 4'b0011;
                    st_data = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        lane_q  = BeMode ? ~off_q : off_q;
        ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SzByte:  ld_data = sign_q ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
            SzHalf:  ld_data = sign_q ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // Next-state logic: accept in IDLE, wait for ack or timeout in WAIT.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        ld_d        = ld_q;
        size_d      = size_q;
        sign_d      = sign_q;
        off_d       = off_q;
        rd_d        = rd_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_valid_d  = 1'b0;
        exc_adel_d  = 1'b0;
        exc_ades_d  = 1'b0;
        bus_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    if (!is_load && !is_store) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_in;
                        wb_data_d  = addr;
                    end else if (misaligned) begin
                        exc_adel_d = is_load;
                        exc_ades_d = is_store;
                    end else begin
                        state_d     = StWait;
                        cnt_d       = 16'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = st_be;
                        mem_wdata_d = st_data;
                        ld_d        = is_load;
                        size_d      = size_in;
                        sign_d      = is_sign;
                        off_d       = addr[1:0];
                        rd_d        = rd_in;
                    end
                end
            end
            StWait: begin
                if (mem_ack) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    if (ld_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = ld_data;
                    end
                end else if (cnt_q == CntMax) begin
                    // This was the last allowed request cycle: abandon the access.
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset clears everything, aborting any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            ld_q        <= 1'b0;
            size_q      <= SzWord;
            sign_q      <= 1'b0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            exc_adel_q  <= 1'b0;
            exc_ades_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            ld_q        <= ld_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_adel_q  <= exc_adel_d;
            exc_ades_q  <= exc_ades_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign stall     = (state_q == StWait);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_adel  = exc_adel_q;
    assign exc_ades  = exc_ades_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a big-endian and a little-endian instance share stimulus
// and memory responses; a byte-level memory model predicts requests and writebacks.
module tb_mem_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [4:0]  rd_in = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        b_stall, b_req, b_we, b_wbv, b_adel, b_ades, b_berr;
    logic [31:0] b_addr, b_wdata, b_wbd;
    logic [3:0]  b_be;
    logic [4:0]  b_wbr;
    logic        l_stall, l_req, l_we, l_wbv, l_adel, l_ades, l_berr;
    logic [31:0] l_addr, l_wdata, l_wbd;
    logic [3:0]  l_be;
    logic [4:0]  l_wbr;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TO), .BIG_ENDIAN(1)) u_be (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .addr(addr),
        .wdata(wdata), .rd_in(rd_in), .stall(b_stall), .mem_req(b_req), .mem_we(b_we),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_be(b_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(b_wbv), .wb_rd(b_wbr), .wb_data(b_wbd),
        .exc_adel(b_adel), .exc_ades(b_ades), .bus_err(b_berr)
    );

    mem_stage #(.TIMEOUT(TO), .BIG_ENDIAN(0)) u_le (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .addr(addr),
        .wdata(wdata), .rd_in(rd_in), .stall(l_stall), .mem_req(l_req), .mem_we(l_we),
        .mem_addr(l_addr), .mem_wdata(l_wdata), .mem_be(l_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(l_wbv), .wb_rd(l_wbr), .wb_data(l_wbd),
        .exc_adel(l_adel), .exc_ades(l_ades), .bus_err(l_berr)
    );

    // kind: 0 writeback, 1 load address error, 2 store address error, 3 bus error
    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] dbe;
        logic [31:0] dle;
        int          due;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be_b;
        logic [3:0]  be_l;
    } req_t;

    resp_t       rq[$];
    req_t        cur;
    resp_t       e;
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0;
    int          win_from = 1, win_to = 0;
    int          ack_at = 0, rcyc = 0;
    logic [31:0] rdata_v = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int op_bytes(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    // Byte at address offset i within the word, under the given byte order.
    function automatic logic [7:0] mbyte(input logic [31:0] w, input int i, input bit be);
        return be ? w[8*(3-i) +: 8] : w[8*i +: 8];
    endfunction

    function automatic logic [31:0] ld_result(input logic [5:0] op, input int o,
                                              input logic [31:0] w, input bit be);
        logic [7:0]  b;
        logic [15:0] h;
        case (op)
            6'h20, 6'h24: begin
                b = mbyte(w, o, be);
                return (op == 6'h20) ? {{24{b[7]}}, b} : {24'b0, b};
            end
            6'h21, 6'h25: begin
                h = be ? {mbyte(w, o, be), mbyte(w, o + 1, be)}
                       : {mbyte(w, o + 1, be), mbyte(w, o, be)};
                return (op == 6'h21) ? {{16{h[15]}}, h} : {16'b0, h};
            end
            default: return w;
        endcase
    endfunction

    // Lane mask covering the bytes the access touches.
    function automatic logic [3:0] lane_mask(input int o, input int nb, input bit be);
        logic [3:0] m = '0;
        for (int i = o; i < o + nb; i++) m[be ? 3 - i : i] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] kind_ev(input int k);
        case (k)
            0:       return 4'b1000;
            1:       return 4'b0100;
            2:       return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // ackat = request cycle (1..) in which memory acks; 0 means never (timeout).
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input int ackat, input logic [31:0] rdat,
                         input bit skip_neg);
        int    guard, n, nb, o, len;
        resp_t r;
        if (!skip_neg) @(negedge clk);
        guard = 0;
        while (b_stall && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_wait: stall still %0b after %0d cycles, expected 0", b_stall,
                     guard);
        end
        valid_in = 1'b1;
        opcode   = op;
        addr     = a;
        wdata    = wd;
        rd_in    = rd;
        ack_at   = ackat;
        rdata_v  = rdat;
        @(posedge clk);
        #1;
        n        = cyc;
        valid_in = 1'b0;
        nb       = op_bytes(op);
        o        = int'(a % 4);
        r.rd     = rd;
        r.dbe    = a;
        r.dle    = a;
        r.due    = n;
        if (nb == 0) begin
            r.kind = 0;
            rq.push_back(r);
        end else if ((a % nb) != 0) begin
            r.kind = op_is_load(op) ? 1 : 2;
            rq.push_back(r);
        end else begin
            len       = (ackat == 0) ? TO : ackat;
            cur.we    = !op_is_load(op);
            cur.addr  = a & 32'hFFFF_FFFC;
            cur.wdata = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
            cur.be_b  = cur.we ? lane_mask(o, nb, 1'b1) : 4'b1111;
            cur.be_l  = cur.we ? lane_mask(o, nb, 1'b0) : 4'b1111;
            win_from  = n;
            win_to    = n + len - 1;
            r.due     = n + len;
            if (ackat == 0) begin
                r.kind = 3;
                rq.push_back(r);
            end else if (op_is_load(op)) begin
                r.kind = 0;
                r.dbe  = ld_result(op, o, rdat, 1'b1);
                r.dle  = ld_result(op, o, rdat, 1'b0);
                rq.push_back(r);
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_be"}, 128'({b_stall, b_req, b_we, b_addr, b_wdata, b_be, b_wbv, b_wbr,
                                b_wbd, b_adel, b_ades, b_berr}), 128'd0);
        chk({tag, "_le"}, 128'({l_stall, l_req, l_we, l_addr, l_wdata, l_be, l_wbv, l_wbr,
                                l_wbd, l_adel, l_ades, l_berr}), 128'd0);
    endtask

    // Memory responder: acks in the chosen request cycle, noise on the bus otherwise.
    always @(negedge clk) begin
        if (rst_n && b_req) begin
            rcyc      = rcyc + 1;
            mem_ack   = (rcyc == ack_at);
            mem_rdata = mem_ack ? rdata_v : $urandom;
        end else begin
            rcyc      = 0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    // Monitor: request window/contents each cycle, and one expected event per due cycle.
    always @(negedge clk) begin
        logic       exp_req, have;
        logic [3:0] ev_b, ev_l, exp_ev;
        if (rst_n) begin
            exp_req = (cyc >= win_from) && (cyc <= win_to);
            chk("req_stall_be", 128'({b_req, b_stall}), 128'({exp_req, exp_req}));
            chk("req_stall_le", 128'({l_req, l_stall}), 128'({exp_req, exp_req}));
            if (exp_req) begin
                chk("req_be", 128'({b_we, b_addr, b_be}), 128'({cur.we, cur.addr, cur.be_b}));
                chk("req_le", 128'({l_we, l_addr, l_be}), 128'({cur.we, cur.addr, cur.be_l}));
                if (cur.we) begin
                    chk("wdata_be", 128'(b_wdata), 128'(cur.wdata));
                    chk("wdata_le", 128'(l_wdata), 128'(cur.wdata));
                end
            end
            ev_b   = {b_wbv, b_adel, b_ades, b_berr};
            ev_l   = {l_wbv, l_adel, l_ades, l_berr};
            exp_ev = 4'b0000;
            have   = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e      = rq.pop_front();
                have   = 1'b1;
                exp_ev = kind_ev(e.kind);
            end
            if (have || ev_b != 4'b0000 || ev_l != 4'b0000) begin
                chk("events_be", 128'(ev_b), 128'(exp_ev));
                chk("events_le", 128'(ev_l), 128'(exp_ev));
                if (have && e.kind == 0) begin
                    chk("wb_be", 128'({b_wbr, b_wbd}), 128'({e.rd, e.dbe}));
                    chk("wb_le", 128'({l_wbr, l_wbd}), 128'({e.rd, e.dle}));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int          ak;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_state");
        rst_n = 1'b1;
        // First acceptance right at the first edge after reset release.
        issue(6'h00, 32'h1234_5678, 32'h0, 5'd5, 0, 32'h0, 1'b1);
        issue(6'h20, 32'h0000_0100, 32'h0, 5'd7, 3, 32'h80FF_0000, 1'b0);
        issue(6'h24, 32'h0000_0100, 32'h0, 5'd8, 3, 32'h80FF_0000, 1'b0);
        issue(6'h29, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9, 1, 32'h0, 1'b0);
        issue(6'h23, 32'h0000_0101, 32'h0, 5'd10, 1, 32'h0, 1'b0);
        issue(6'h29, 32'h0000_0203, 32'h1111_2222, 5'd11, 1, 32'h0, 1'b0);
        issue(6'h23, 32'h0000_0400, 32'h0, 5'd12, 0, 32'h0, 1'b0);
        issue(6'h00, 32'hCAFE_0001, 32'h0, 5'd13, 0, 32'h0, 1'b0);
        issue(6'h23, 32'h0000_0404, 32'h0, 5'd14, TO, 32'hDEAD_BEEF, 1'b0);
        issue(6'h21, 32'h0000_0502, 32'h0, 5'd15, 2, 32'h1234_8765, 1'b0);
        issue(6'h28, 32'h0000_0603, 32'h0000_00A5, 5'd16, 1, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 8))
                0: op = 6'h20;
                1: op = 6'h21;
                2: op = 6'h23;
                3: op = 6'h24;
                4: op = 6'h25;
                5: op = 6'h28;
                6: op = 6'h29;
                7: op = 6'h2B;
                default: begin
                    do op = 6'($urandom_range(0, 63)); while (op_bytes(op) != 0);
                end
            endcase
            a  = $urandom;
            ak = $urandom_range(0, TO);
            issue(op, a, $urandom, 5'($urandom), ak, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Reset pulse while a load is waiting: request falls at once, nothing written back.
        issue(6'h23, 32'h0000_0800, 32'h0, 5'd20, 0, 32'h0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("reset_mid_wait");
        rq.delete();
        win_from = 1;
        win_to   = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(6'h00, 32'h5555_AAAA, 32'h0, 5'd21, 0, 32'h0, 1'b1);
        issue(6'h25, 32'h0000_0902, 32'h0, 5'd22, 2, 32'hFEDC_BA98, 1'b0);
        repeat (TO + 4) @(negedge clk);
        #1;
        chk("scoreboard_drained", 128'(rq.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
